// File: rtl/vec_issue_ctrl_if.sv
// Handshake bundle between the instruction source and the vector issue controller.
// The master modport is the instruction source / micro-op sink; the slave modport is the controller.
interface vec_issue_ctrl_if #(
    parameter int VLEN  = 8,
    parameter int LANES = 4,
    parameter int OPW   = 6
);
    localparam int BEATS = VLEN / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LBW   = $clog2(VLEN) + 1;

    logic           in_valid;
    logic [OPW-1:0] op;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [13:0]    ctrl;
    logic [BW-1:0]  beat_idx;
    logic [LBW-1:0] lane_base;
    logic           last_beat;
    logic           running;

    modport master (
        output in_valid, op, out_ready,
        input  in_ready, out_valid, ctrl, beat_idx, lane_base, last_beat, running
    );

    modport slave (
        input  in_valid, op, out_ready,
        output in_ready, out_valid, ctrl, beat_idx, lane_base, last_beat, running
    );
endinterface

// File: rtl/vec_issue_ctrl.sv
// Vector issue controller: decodes opcodes into 14-bit control words and splits
// vector-class instructions into LANES-wide beats.
module vec_issue_ctrl #(
    parameter int VLEN  = 8,
    parameter int LANES = 4,
    parameter int OPW   = 6
) (
    input logic           clk,
    input logic           rst,
    vec_issue_ctrl_if.slave bus
);
    localparam int BEATS = VLEN / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LBW   = $clog2(VLEN) + 1;
    localparam int LOG2L = $clog2(LANES);

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    localparam logic [OPW-1:0] OP_START = OPW'(6'b110010);
    localparam logic [OPW-1:0] OP_STOP  = OPW'(6'b110001);

    logic [1:0]    r_state;
    logic [13:0]   r_ctrl;
    logic [BW-1:0] r_beat;
    logic          r_vec;

    logic          w_issuing;
    logic          w_last;
    logic          w_inReady;
    logic          w_accept;
    logic          w_isStart;
    logic          w_isStop;
    logic          w_isVec;
    logic [13:0]   w_decCtrl;

    always_comb begin
        w_decCtrl = 14'b0;
        case (bus.op)
            OPW'(6'b000000): w_decCtrl = 14'b10_0000_001_00_0_10;
            OPW'(6'b010000): w_decCtrl = 14'b10_0000_100_00_0_00;
            OPW'(6'b000100): w_decCtrl = 14'b01_0000_011_00_0_10;
            OPW'(6'b001100): w_decCtrl = 14'b01_0000_001_00_0_10;
            OPW'(6'b010001): w_decCtrl = 14'b00_0100_100_00_0_00;
            OPW'(6'b010010): w_decCtrl = 14'b10_1000_100_00_0_00;
            OPW'(6'b010101): w_decCtrl = 14'b00_0110_100_00_0_00;
            OPW'(6'b010110): w_decCtrl = 14'b01_1010_100_00_0_00;
            OPW'(6'b011101): w_decCtrl = 14'b00_0101_100_00_0_00;
            OPW'(6'b011110): w_decCtrl = 14'b01_1001_100_00_0_00;
            OPW'(6'b100000): w_decCtrl = 14'b00_0000_000_01_0_00;
            OPW'(6'b100001): w_decCtrl = 14'b00_0000_000_10_0_00;
            OPW'(6'b100010): w_decCtrl = 14'b00_0000_000_00_1_00;
            OPW'(6'b111111): w_decCtrl = 14'b01_0000_100_00_0_01;
            default:         w_decCtrl = 14'b0;
        endcase
    end

    // With a single beat per register, vector ops degenerate to ordinary single-beat ops.
    assign w_isVec   = (BEATS > 1) &&
                       ((bus.op == OPW'(6'b001100)) ||
                        (bus.op == OPW'(6'b011101)) ||
                        (bus.op == OPW'(6'b011110)));
    assign w_isStart = (bus.op == OP_START);
    assign w_isStop  = (bus.op == OP_STOP);

    assign w_issuing = (r_state == S_ISSUE);
    assign w_last    = !r_vec || (r_beat == BW'(BEATS - 1));

    // Accepting during ISSUE only on the final beat's handshake gives zero-bubble back-to-back issue.
    assign w_inReady = !w_issuing || (bus.out_ready && w_last);
    assign w_accept  = bus.in_valid && w_inReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_OFF;
            r_ctrl  <= 14'b0;
            r_beat  <= '0;
            r_vec   <= 1'b0;
        end else begin
            case (r_state)
                S_OFF: begin
                    if (w_accept && w_isStart) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE, S_ISSUE: begin
                    if (w_issuing && bus.out_ready && !w_last) begin
                        r_beat <= r_beat + BW'(1);
                    end else if (!w_issuing || bus.out_ready) begin
                        if (w_accept && w_isStop) begin
                            r_state <= S_OFF;
                        end else if (w_accept && !w_isStart) begin
                            r_state <= S_ISSUE;
                            r_ctrl  <= w_decCtrl;
                            r_beat  <= '0;
                            r_vec   <= w_isVec;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_OFF;
                end
            endcase
        end
    end

    // Micro-op fields read as zero whenever no micro-op is being presented.
    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_issuing;
    assign bus.ctrl      = w_issuing ? r_ctrl : 14'b0;
    assign bus.beat_idx  = w_issuing ? r_beat : '0;
    assign bus.lane_base = w_issuing ? (LBW'(r_beat) << LOG2L) : '0;
    assign bus.last_beat = w_issuing && w_last;
    assign bus.running   = (r_state != S_OFF);

endmodule
